// File: rtl/ws_conv_ctrl_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// ws_conv_ctrl_if: memory, PE-array and handshake bundle of ws_conv_ctrl. Rev 1.0
// ------------------------------------------------------------------------
interface ws_conv_ctrl_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [3:0]  wgt_addr;
  logic [7:0]  wgt_data;
  logic [9:0]  img_addr1;
  logic [9:0]  img_addr2;
  logic [9:0]  img_addr3;
  logic [7:0]  img_data1;
  logic [7:0]  img_data2;
  logic [7:0]  img_data3;
  logic        load_w;
  logic        en;
  logic        clr;
  logic [71:0] w_bus;
  logic [7:0]  bias;
  logic [7:0]  x1;
  logic [7:0]  x2;
  logic [7:0]  x3;
  logic        res_valid;
  logic [4:0]  res_row;
  logic [4:0]  res_col;

  modport master (
    input  start, wgt_data, img_data1, img_data2, img_data3,
    output busy, done, wgt_addr, img_addr1, img_addr2, img_addr3,
           load_w, en, clr, w_bus, bias, x1, x2, x3,
           res_valid, res_row, res_col
  );

  modport slave (
    output start, wgt_data, img_data1, img_data2, img_data3,
    input  busy, done, wgt_addr, img_addr1, img_addr2, img_addr3,
           load_w, en, clr, w_bus, bias, x1, x2, x3,
           res_valid, res_row, res_col
  );
endinterface
`default_nettype wire

// File: rtl/ws_conv_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------------
// ws_conv_ctrl: sequencer for a weight-stationary 3x3 PE array. Rev 1.0
// ------------------------------------------------------------------------
module ws_conv_ctrl #(
  parameter int IMG_WIDTH = 5,
  parameter int RES_LAT   = 4
) (
  input  wire            sys_clk,
  input  wire            rst_n,
  ws_conv_ctrl_if.master bus
);
  localparam int         OUT_W   = IMG_WIDTH - 2;
  localparam int         SR_LEN  = RES_LAT + 5;
  localparam logic [4:0] LAST_RC = 5'(OUT_W - 1);
  localparam logic [9:0] W10     = 10'(IMG_WIDTH);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOADW  = 3'd1;
  localparam logic [2:0] LATCH  = 3'd2;
  localparam logic [2:0] STREAM = 3'd3;
  localparam logic [2:0] DRAIN  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [2:0]        ph_q, ph_d;
  logic [4:0]        wr_q, wr_d;
  logic [4:0]        wc_q, wc_d;
  logic              ldv_q;
  logic [3:0]        ldi_q;
  logic [71:0]       w_bus_q;
  logic [7:0]        bias_q;
  logic              v1_q, v2_q, v3_q;
  logic [SR_LEN-1:0] sr_q;
  logic [4:0]        nr_q, nc_q;
  logic [4:0]        res_row_q, res_col_q;
  logic              en_q;

  logic       stream, last_win, res_valid;
  logic [9:0] base, ph10;

  assign stream    = (state_q == STREAM);
  assign last_win  = (wr_q == LAST_RC) && (wc_q == LAST_RC);
  assign res_valid = sr_q[SR_LEN-1];
  assign base      = 10'(wr_q) * W10 + 10'(wc_q);
  assign ph10      = 10'(ph_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    wr_d    = wr_q;
    wc_d    = wc_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOADW;
          cnt_d   = 4'd0;
        end
      end
      // One extra LOADW cycle (cnt=10) lets the address-9 data land in bias.
      LOADW: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd10) state_d = LATCH;
      end
      LATCH: begin
        state_d = STREAM;
        ph_d    = 3'd0;
        wr_d    = 5'd0;
        wc_d    = 5'd0;
      end
      STREAM: begin
        if (ph_q == 3'd4) begin
          ph_d = 3'd0;
          if (last_win) begin
            state_d = DRAIN;
          end else if (wc_q == LAST_RC) begin
            wc_d = 5'd0;
            wr_d = wr_q + 5'd1;
          end else begin
            wc_d = wc_q + 5'd1;
          end
        end else begin
          ph_d = ph_q + 3'd1;
        end
      end
      DRAIN:   if (res_valid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ph_q      <= '0;
      wr_q      <= '0;
      wc_q      <= '0;
      ldv_q     <= 1'b0;
      ldi_q     <= '0;
      w_bus_q   <= '0;
      bias_q    <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      sr_q      <= '0;
      nr_q      <= '0;
      nc_q      <= '0;
      res_row_q <= '0;
      res_col_q <= '0;
      en_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      wr_q    <= wr_d;
      wc_q    <= wc_d;
      ldv_q   <= (state_q == LOADW) && (cnt_q <= 4'd9);
      ldi_q   <= cnt_q;
      if (ldv_q) begin
        if (ldi_q == 4'd9) begin
          bias_q <= bus.wgt_data;
        end else begin
          for (int k = 0; k < 9; k++) begin
            if (ldi_q == 4'(k)) w_bus_q[8*k +: 8] <= bus.wgt_data;
          end
        end
      end
      // Row n of the array sees its samples n-1 cycles after row 1.
      v1_q <= stream && (ph_q <= 3'd2);
      v2_q <= stream && (ph_q >= 3'd1) && (ph_q <= 3'd3);
      v3_q <= stream && (ph_q >= 3'd2);
      sr_q <= {sr_q[SR_LEN-2:0], stream && (ph_q == 3'd0)};
      if (state_q == LATCH) begin
        nr_q <= '0;
        nc_q <= '0;
      end else if (sr_q[SR_LEN-2]) begin
        res_row_q <= nr_q;
        res_col_q <= nc_q;
        if (nc_q == LAST_RC) begin
          nc_q <= '0;
          nr_q <= (nr_q == LAST_RC) ? 5'd0 : nr_q + 5'd1;
        end else begin
          nc_q <= nc_q + 5'd1;
        end
      end
      en_q <= stream || ((state_q == DRAIN) && !res_valid);
    end
  end

  assign bus.busy      = (state_q != IDLE) && (state_q != DONE);
  assign bus.done      = (state_q == DONE);
  assign bus.load_w    = (state_q == LATCH);
  assign bus.clr       = stream && (ph_q == 3'd1);
  assign bus.en        = en_q;
  assign bus.wgt_addr  = ((state_q == LOADW) && (cnt_q <= 4'd9)) ? cnt_q : 4'd0;
  assign bus.img_addr1 = (stream && (ph_q <= 3'd2)) ? base + ph10 : 10'd0;
  assign bus.img_addr2 = (stream && (ph_q >= 3'd1) && (ph_q <= 3'd3)) ?
                         base + W10 + ph10 - 10'd1 : 10'd0;
  assign bus.img_addr3 = (stream && (ph_q >= 3'd2)) ?
                         base + W10 + W10 + ph10 - 10'd2 : 10'd0;
  assign bus.w_bus     = w_bus_q;
  assign bus.bias      = bias_q;
  assign bus.x1        = v1_q ? bus.img_data1 : 8'd0;
  assign bus.x2        = v2_q ? bus.img_data2 : 8'd0;
  assign bus.x3        = v3_q ? bus.img_data3 : 8'd0;
  assign bus.res_valid = res_valid;
  assign bus.res_row   = res_row_q;
  assign bus.res_col   = res_col_q;
endmodule
`default_nettype wire

// File: tb/tb_ws_conv_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_ws_conv_ctrl: directed bench for ws_conv_ctrl at IMG_WIDTH 5 and 3. Rev 1.0
// ------------------------------------------------------------------------
module tb_ws_conv_ctrl;
  localparam int RES_LAT = 4;
  localparam logic [71:0] WBUS_EXP = 72'h09_08_07_06_05_04_03_02_01;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  ws_conv_ctrl_if i5 ();
  ws_conv_ctrl_if i3 ();

  ws_conv_ctrl #(.IMG_WIDTH(5), .RES_LAT(RES_LAT)) u_dut5 (
    .sys_clk(clk), .rst_n(rst_n), .bus(i5.master));
  ws_conv_ctrl #(.IMG_WIDTH(3), .RES_LAT(RES_LAT)) u_dut3 (
    .sys_clk(clk), .rst_n(rst_n), .bus(i3.master));

  always #5 clk = ~clk;

  // Memories: weight k = k+1, bias (address 9) = 10, img[i] = i.
  always @(posedge clk) begin
    i5.wgt_data  <= (i5.wgt_addr < 4'd9) ? {4'd0, i5.wgt_addr} + 8'd1 : 8'd10;
    i5.img_data1 <= i5.img_addr1[7:0];
    i5.img_data2 <= i5.img_addr2[7:0];
    i5.img_data3 <= i5.img_addr3[7:0];
    i3.wgt_data  <= (i3.wgt_addr < 4'd9) ? {4'd0, i3.wgt_addr} + 8'd1 : 8'd10;
    i3.img_data1 <= i3.img_addr1[7:0];
    i3.img_data2 <= i3.img_addr2[7:0];
    i3.img_data3 <= i3.img_addr3[7:0];
  end

  task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Expected behaviour at cycle S+rel, derived from the pass timing formulas.
  task automatic check_cycle(input string id, input int w, input int rel,
                             input logic busy, done, load_w, en, clr, rv,
                             input logic [4:0] rr, rc,
                             input logic [7:0] x1, x2, x3,
                             input logic [9:0] a1, a2, a3,
                             input logic [3:0] wa);
    int ow, n, dn, r, c, b, t, e1, e2, e3;
    logic erv;
    ow = w - 2;
    n  = ow * ow;
    dn = 14 + 5 * n + RES_LAT;
    e1 = 0; e2 = 0; e3 = 0; erv = 1'b0;
    chk($sformatf("%s.busy@%0d", id, rel), busy, (rel >= 1) && (rel < dn));
    chk($sformatf("%s.done@%0d", id, rel), done, rel == dn);
    chk($sformatf("%s.load_w@%0d", id, rel), load_w, rel == 12);
    chk($sformatf("%s.en@%0d", id, rel), en, (rel >= 14) && (rel < dn));
    chk($sformatf("%s.clr@%0d", id, rel), clr,
        (rel >= 14) && ((rel - 14) % 5 == 0) && ((rel - 14) / 5 < n));
    if (rel >= 1 && rel <= 10) chk($sformatf("%s.wgt_addr@%0d", id, rel), wa, rel - 1);
    for (int k = 0; k < n; k++) begin
      r = k / ow;
      c = k % ow;
      b = 14 + 5 * k;
      t = rel - b;     if (t >= 0 && t <= 2) e1 = r * w + c + t;
      t = rel - b - 1; if (t >= 0 && t <= 2) e2 = (r + 1) * w + c + t;
      t = rel - b - 2; if (t >= 0 && t <= 2) e3 = (r + 2) * w + c + t;
      t = rel + 1 - b;
      if (t >= 0 && t <= 2) chk($sformatf("%s.a1@%0d", id, rel), a1, r * w + c + t);
      t = rel - b;
      if (t >= 0 && t <= 2) chk($sformatf("%s.a2@%0d", id, rel), a2, (r + 1) * w + c + t);
      t = rel - 1 - b;
      if (t >= 0 && t <= 2) chk($sformatf("%s.a3@%0d", id, rel), a3, (r + 2) * w + c + t);
      if (rel == b + 4 + RES_LAT || rel == b + 6 + RES_LAT) begin
        chk($sformatf("%s.res_row@%0d", id, rel), rr, r);
        chk($sformatf("%s.res_col@%0d", id, rel), rc, c);
      end
      if (rel == b + 4 + RES_LAT) erv = 1'b1;
    end
    chk($sformatf("%s.res_valid@%0d", id, rel), rv, erv);
    chk($sformatf("%s.x1@%0d", id, rel), x1, e1);
    chk($sformatf("%s.x2@%0d", id, rel), x2, e2);
    chk($sformatf("%s.x3@%0d", id, rel), x3, e3);
  endtask

  task automatic cyc_both(input int rel);
    check_cycle("w5", 5, rel, i5.busy, i5.done, i5.load_w, i5.en, i5.clr, i5.res_valid,
                i5.res_row, i5.res_col, i5.x1, i5.x2, i5.x3,
                i5.img_addr1, i5.img_addr2, i5.img_addr3, i5.wgt_addr);
    check_cycle("w3", 3, rel, i3.busy, i3.done, i3.load_w, i3.en, i3.clr, i3.res_valid,
                i3.res_row, i3.res_col, i3.x1, i3.x2, i3.x3,
                i3.img_addr1, i3.img_addr2, i3.img_addr3, i3.wgt_addr);
  endtask

  task automatic chk_zero(input string id, input logic [71:0] wb, input logic [7:0] bs,
                          input logic [73:0] misc);
    chk({id, ".w_bus"}, wb, 0);
    chk({id, ".bias"}, bs, 0);
    chk({id, ".outs"}, misc, 0);
  endtask

  task automatic chk_zero_both(input string id);
    chk_zero({id, ".w5"}, i5.w_bus, i5.bias,
             {i5.res_row, i5.res_col, i5.img_addr1, i5.img_addr2, i5.img_addr3, i5.wgt_addr,
              i5.x1, i5.x2, i5.x3, i5.busy, i5.done, i5.load_w, i5.en, i5.clr, i5.res_valid});
    chk_zero({id, ".w3"}, i3.w_bus, i3.bias,
             {i3.res_row, i3.res_col, i3.img_addr1, i3.img_addr2, i3.img_addr3, i3.wgt_addr,
              i3.x1, i3.x2, i3.x3, i3.busy, i3.done, i3.load_w, i3.en, i3.clr, i3.res_valid});
  endtask

  // Starts a pass; stop_rel >= 0 returns early at that relative cycle.
  task automatic run_pass(input bit mid_start, input int stop_rel);
    int last;
    last = 14 + 5 * 9 + RES_LAT + 3;
    @(negedge clk);
    i5.start = 1'b1;
    i3.start = 1'b1;
    cyc_both(0);
    for (int rel = 1; rel <= last; rel++) begin
      @(negedge clk);
      i5.start = mid_start && (rel == 20);
      i3.start = mid_start && (rel == 20);
      cyc_both(rel);
      if (rel == 12) begin
        chk("w5.w_bus@12", i5.w_bus, WBUS_EXP);
        chk("w5.bias@12", i5.bias, 10);
        chk("w3.w_bus@12", i3.w_bus, WBUS_EXP);
        chk("w3.bias@12", i3.bias, 10);
      end
      if (rel == stop_rel) return;
    end
  endtask

  initial begin
    i5.start = 1'b0;
    i3.start = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero_both("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_pass(1'b1, -1);
    chk("w5.w_bus.hold", i5.w_bus, WBUS_EXP);
    chk("w5.bias.hold", i5.bias, 10);
    chk("w5.res_rc.hold", {i5.res_row, i5.res_col}, {5'd2, 5'd2});

    run_pass(1'b0, 30);
    #1 rst_n = 1'b0;
    #1 chk_zero_both("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("w5.postrst.done_busy@%0d", i), {i5.done, i5.busy}, 0);
      chk($sformatf("w3.postrst.done_busy@%0d", i), {i3.done, i3.busy}, 0);
    end

    run_pass(1'b0, -1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
